// File: rtl/timer_in_control_pkg.sv
// Shared types and constants for the microwave timer keypad front-end.
package timer_in_control_pkg;

    localparam int NUM_KEYS = 10;
    localparam int BCD_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PULSE,
        HELD,
        DEB_REL
    } state_t;

    // Highest-numbered active key wins; ascending scan lets later hits overwrite.
    function automatic logic [BCD_W-1:0] prio_encode(input logic [NUM_KEYS-1:0] k);
        logic [BCD_W-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (k[i]) res = i[BCD_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_pulse_div.sv
// Free-running clock divider producing the 50 % duty 1 Hz timebase.
module timer_pulse_div #(
    parameter int CLK_DIV = 100
) (
    input  logic clock,
    input  logic Nreset,
    output logic pgt_1Hz
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!Nreset) begin
            cnt     <= '0;
            pgt_1Hz <= 1'b0;
        end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (cnt == HALF || cnt == LAST) pgt_1Hz <= ~pgt_1Hz;
        end
    end

endmodule

// File: rtl/timer_in_control.sv
// Keypad synchroniser, debouncer and BCD encoder with one-shot load strobe,
// plus the 1 Hz timebase for the downstream timer chain.
module timer_in_control
    import timer_in_control_pkg::*;
#(
    parameter int CLK_DIV  = 100,
    parameter int DEBOUNCE = 2
) (
    input  logic             key0,
    input  logic             key1,
    input  logic             key2,
    input  logic             key3,
    input  logic             key4,
    input  logic             key5,
    input  logic             key6,
    input  logic             key7,
    input  logic             key8,
    input  logic             key9,
    input  logic             Nenable,
    input  logic             clock,
    input  logic             Nreset,
    output logic [BCD_W-1:0] dados,
    output logic             loadn,
    output logic             pgt_1Hz
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE - 1);

    logic [NUM_KEYS-1:0] keys, sync1, sync2;
    logic                any;
    logic [BCD_W-1:0]    code;
    state_t              state, state_n;
    logic [DB_W-1:0]     cnt, cnt_n;
    logic [BCD_W-1:0]    dados_n;

    assign keys = {key9, key8, key7, key6, key5, key4, key3, key2, key1, key0};
    assign any  = |sync2;
    assign code = prio_encode(sync2);

    always_ff @(posedge clock) begin
        if (!Nreset) begin
            sync1 <= '0;
            sync2 <= '0;
            state <= IDLE;
            cnt   <= '0;
            dados <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            state <= state_n;
            cnt   <= cnt_n;
            dados <= dados_n;
        end
    end

    // A key seen while disabled is parked in HELD so it cannot strobe after re-enable.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dados_n = dados;
        loadn   = 1'b1;
        case (state)
            IDLE: begin
                if (any) begin
                    cnt_n   = DB_LOAD;
                    state_n = Nenable ? HELD : DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (Nenable) begin
                    state_n = HELD;
                end else if (!any) begin
                    state_n = IDLE;
                end else if (cnt == '0) begin
                    state_n = PULSE;
                    dados_n = code;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            PULSE: begin
                loadn   = Nenable;
                state_n = HELD;
            end
            HELD: begin
                if (!any) begin
                    cnt_n   = DB_LOAD;
                    state_n = DEB_REL;
                end
            end
            DEB_REL: begin
                if (any) begin
                    state_n = HELD;
                end else if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    timer_pulse_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clock   (clock),
        .Nreset  (Nreset),
        .pgt_1Hz (pgt_1Hz)
    );

endmodule

// File: tb/tb_timer_in_control.sv
// Directed self-checking bench for timer_in_control (CLK_DIV=4, DEBOUNCE=2).
module tb_timer_in_control;

    logic       clock = 1'b0;
    logic       Nreset = 1'b0;
    logic       Nenable = 1'b0;
    logic       key0 = 0, key1 = 0, key2 = 0, key3 = 0, key4 = 0;
    logic       key5 = 0, key6 = 0, key7 = 0, key8 = 0, key9 = 0;
    logic [3:0] dados;
    logic       loadn;
    logic       pgt_1Hz;

    int n_checks = 0;
    int n_errors = 0;
    int since_rel = 0;
    bit chk_div = 1'b0;

    timer_in_control #(
        .CLK_DIV  (4),
        .DEBOUNCE (2)
    ) dut (
        .key0 (key0), .key1 (key1), .key2 (key2), .key3 (key3), .key4 (key4),
        .key5 (key5), .key6 (key6), .key7 (key7), .key8 (key8), .key9 (key9),
        .Nenable (Nenable),
        .clock   (clock),
        .Nreset  (Nreset),
        .dados   (dados),
        .loadn   (loadn),
        .pgt_1Hz (pgt_1Hz)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Divider reference: edges since reset release, pattern 0,0,1,1 per 4 cycles.
    always @(posedge clock) since_rel <= Nreset ? since_rel + 1 : 0;

    always @(negedge clock) begin
        if (chk_div) check("pgt_1Hz", {31'b0, pgt_1Hz}, {31'b0, ((since_rel % 4) >= 2)});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // strobe_at: tick index (1-based) where loadn must be low; 0 = none.
    task automatic run(input string tag, input int n, input int strobe_at,
                       input logic [3:0] d_before, input logic [3:0] d_after);
        for (int i = 1; i <= n; i++) begin
            tick();
            check({tag, ".loadn"}, {31'b0, loadn}, {31'b0, !(i == strobe_at)});
            check({tag, ".dados"}, {28'b0, dados},
                  {28'b0, (strobe_at != 0 && i >= strobe_at) ? d_after : d_before});
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst.dados", {28'b0, dados}, 32'd0);
        check("rst.loadn", {31'b0, loadn}, 32'd1);
        check("rst.pgt", {31'b0, pgt_1Hz}, 32'd0);
        chk_div = 1'b1;
        Nreset = 1'b1;

        // single press: strobe 4 edges after first sample, no repeat
        key7 = 1; run("press7", 15, 5, 4'd0, 4'd7);
        key7 = 0; run("rel7", 6, 0, 4'd7, 4'd7);

        // enable gating: key pressed while disabled, held across re-enable
        Nenable = 1; key7 = 1; run("dis7", 6, 0, 4'd7, 4'd7);
        Nenable = 0;           run("reen7", 8, 0, 4'd7, 4'd7);
        key7 = 0;              run("rel7b", 6, 0, 4'd7, 4'd7);
        key3 = 1; run("press3", 10, 5, 4'd7, 4'd3);
        key3 = 0; run("rel3", 6, 0, 4'd3, 4'd3);

        // priority: 2 and 9 together
        key2 = 1; key9 = 1; run("prio", 10, 5, 4'd3, 4'd9);
        key2 = 0; key9 = 0; run("relprio", 6, 0, 4'd9, 4'd9);

        // 1-cycle glitch on key5
        key5 = 1; run("glitch", 1, 0, 4'd9, 4'd9);
        key5 = 0; run("glitchq", 8, 0, 4'd9, 4'd9);

        // re-press: short release gives no strobe, long release does
        key1 = 1; run("press1", 8, 5, 4'd9, 4'd1);
        key1 = 0; run("gap1", 1, 0, 4'd1, 4'd1);
        key1 = 1; run("repress1", 8, 0, 4'd1, 4'd1);
        key1 = 0; run("rel1", 6, 0, 4'd1, 4'd1);
        key1 = 1; run("press1b", 8, 5, 4'd1, 4'd1);
        key1 = 0; run("rel1b", 6, 0, 4'd1, 4'd1);

        // disable during press debounce: parked in HELD, no strobe on re-enable
        key6 = 1; run("deb6", 3, 0, 4'd1, 4'd1);
        Nenable = 1; run("dis6", 6, 0, 4'd1, 4'd1);
        Nenable = 0; run("reen6", 4, 0, 4'd1, 4'd1);
        key6 = 0; run("rel6", 6, 0, 4'd1, 4'd1);

        // reset in the middle of a strobe
        key4 = 1; run("press4", 5, 5, 4'd1, 4'd4);
        Nreset = 0; run("rstmid", 1, 0, 4'd0, 4'd0);
        Nreset = 1; key4 = 0; run("postrst", 6, 0, 4'd0, 4'd0);

        chk_div = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
